icache_controller: RTL

- Direct-mapped, read-only instruction cache controller between the RV32IMF fetch stage and the byte-addressed instruction memory.
- Serves hits in the same cycle as the request.
- On a miss, sequences a block read from the instruction memory, fills the line, then replays the request.
- Stalls fetch via BUSYWAIT; supports a whole-cache FLUSH for fence.i.

---
 rtl/icache_pkg.sv | 44 ++++
 rtl/icache_line_store.sv | 45 ++++
 rtl/icache_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared state encoding, field widths and PC field extraction for the instruction cache.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package icache_pkg;

  localparam int ADDR_WIDTH       = 10;
  localparam int INDEX_BITS       = 3;
  localparam int WORD_OFFSET_BITS = 2;
  localparam int TAG_BITS         = ADDR_WIDTH - INDEX_BITS - WORD_OFFSET_BITS - 2;
  localparam int NUM_LINES        = 1 << INDEX_BITS;
  localparam int WORD_WIDTH       = 32;
  localparam int BLOCK_WIDTH      = WORD_WIDTH << WORD_OFFSET_BITS;
  localparam int MEM_ADDR_WIDTH   = TAG_BITS + INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  typedef logic [TAG_BITS-1:0]         tag_t;
  typedef logic [INDEX_BITS-1:0]       index_t;
  typedef logic [WORD_OFFSET_BITS-1:0] offset_t;

  // Tag is the top of the used address range; upper PC bits never reach here.
  function automatic tag_t get_tag(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1 -: TAG_BITS];
  endfunction

  function automatic index_t get_index(input logic [ADDR_WIDTH-1:0] addr);
    return addr[WORD_OFFSET_BITS+2 +: INDEX_BITS];
  endfunction

  function automatic offset_t get_offset(input logic [ADDR_WIDTH-1:0] addr);
    return addr[2 +: WORD_OFFSET_BITS];
  endfunction

  // Word 0 of a block sits in the least significant 32 bits.
  function automatic logic [WORD_WIDTH-1:0] get_word(input logic [BLOCK_WIDTH-1:0] blk,
                                                     input offset_t off);
    return blk[off*WORD_WIDTH +: WORD_WIDTH];
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the direct-mapped cache lines, one read port and one write port.
// Latency: read is combinational, write and clear-all take effect at the next clock edge.
// Backpressure: none, every write and clear is accepted in the cycle it is presented.
module icache_line_store
  import icache_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_wr_en,
  input  logic [INDEX_BITS-1:0]  i_wr_index,
  input  logic [TAG_BITS-1:0]    i_wr_tag,
  input  logic [BLOCK_WIDTH-1:0] i_wr_data,
  input  logic [INDEX_BITS-1:0]  i_rd_index,
  output logic                   o_rd_valid,
  output logic [TAG_BITS-1:0]    o_rd_tag,
  output logic [BLOCK_WIDTH-1:0] o_rd_data
);

  logic [NUM_LINES-1:0]   r_valid;
  logic [TAG_BITS-1:0]    r_tag  [NUM_LINES];
  logic [BLOCK_WIDTH-1:0] r_data [NUM_LINES];

  // Valid bits: reset and clear-all take priority over a line fill.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag/data payload has no reset; it is only ever consumed through a set valid bit.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache: hit detection, miss fill sequencing and flush.
// Latency: hits return in the request cycle; a miss costs 2 cycles plus the memory busy cycles.
// Backpressure: BUSYWAIT stalls fetch on a miss; MEM_BUSYWAIT holds the fill in MEM_READ.
module icache_controller
  import icache_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      CPU_READ,
  input  logic [31:0]               PC,
  output logic [WORD_WIDTH-1:0]     INSTRUCTION,
  output logic                      BUSYWAIT,
  input  logic                      FLUSH,
  output logic                      MEM_READ,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_ADDRESS,
  input  logic [BLOCK_WIDTH-1:0]    MEM_READDATA,
  input  logic                      MEM_BUSYWAIT
);

  state_t                    r_state;
  logic                      r_flush_pending;
  logic                      r_mem_read;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_address;
  logic [WORD_WIDTH-1:0]     r_instr;
  logic [BLOCK_WIDTH-1:0]    r_fill_data;

  logic [ADDR_WIDTH-1:0]     w_addr;
  tag_t                      w_tag;
  index_t                    w_index;
  offset_t                   w_offset;
  logic                      w_line_valid;
  tag_t                      w_line_tag;
  logic [BLOCK_WIDTH-1:0]    w_line_data;
  logic                      w_idle;
  logic                      w_flush_now;
  logic                      w_hit;
  logic                      w_serve;
  logic                      w_wr_en;
  logic [WORD_WIDTH-1:0]     w_word;
  logic                      w_unused_pc_bits;

  // Upper PC bits are outside the cached range and [1:0] are always word aligned.
  assign w_unused_pc_bits = ^{PC[31:ADDR_WIDTH], PC[1:0]};

  assign w_addr   = PC[ADDR_WIDTH-1:0];
  assign w_tag    = get_tag(w_addr);
  assign w_index  = get_index(w_addr);
  assign w_offset = get_offset(w_addr);

  assign w_idle      = (r_state == IDLE);
  // A flush seen in IDLE (fresh pulse or one deferred during a fill) wipes the cache this edge,
  // so a request in the same cycle must not be served from the soon-to-be-invalid line.
  assign w_flush_now = FLUSH || r_flush_pending;
  assign w_hit       = w_line_valid && (w_line_tag == w_tag);
  assign w_serve     = w_idle && CPU_READ && w_hit && !w_flush_now;
  assign w_wr_en     = (r_state == UPDATE);
  assign w_word      = get_word(w_line_data, w_offset);

  assign BUSYWAIT    = w_idle ? (CPU_READ && !w_serve) : 1'b1;
  assign INSTRUCTION = w_serve ? w_word : r_instr;
  assign MEM_READ    = r_mem_read;
  assign MEM_ADDRESS = r_mem_address;

  icache_line_store u_line_store (
    .i_clk      (CLK),
    .i_rst_n    (RESET),
    .i_clear    (w_idle && w_flush_now),
    .i_wr_en    (w_wr_en),
    .i_wr_index (r_mem_address[INDEX_BITS-1:0]),
    .i_wr_tag   (r_mem_address[MEM_ADDR_WIDTH-1:INDEX_BITS]),
    .i_wr_data  (r_fill_data),
    .i_rd_index (w_index),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_line_data)
  );

  // Miss-handling FSM with registered memory-side outputs and the last-served instruction.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state         <= IDLE;
      r_flush_pending <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_address   <= '0;
      r_instr         <= '0;
      r_fill_data     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Any deferred flush is applied by the line store this edge.
          r_flush_pending <= 1'b0;
          if (CPU_READ) begin
            if (w_serve) begin
              r_instr <= w_word;
            end else begin
              r_mem_address <= {w_tag, w_index};
              r_mem_read    <= 1'b1;
              r_state       <= icache_pkg::MEM_READ;
            end
          end
        end
        icache_pkg::MEM_READ: begin
          if (FLUSH) begin
            r_flush_pending <= 1'b1;
          end
          // Data is valid in the first cycle the memory drops its busy flag.
          if (!MEM_BUSYWAIT) begin
            r_fill_data <= MEM_READDATA;
            r_mem_read  <= 1'b0;
            r_state     <= UPDATE;
          end
        end
        UPDATE: begin
          if (FLUSH) begin
            r_flush_pending <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: begin
          r_mem_read <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule
